// File: rtl/controlador_interrupciones_pkg.sv
// Shared definitions for the interrupt controller and the CPU-side decode:
// source count, FSM encodings and a one-hot helper.
package controlador_interrupciones_pkg;

  localparam int NUM_SRC = 8;
  localparam int IDX_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_REQ     = 2'b01,
    ST_SERVICE = 2'b10
  } estado_t;

  function automatic logic [NUM_SRC-1:0] decodifica(input logic [IDX_W-1:0] idx);
    logic [NUM_SRC-1:0] v;
    v = {{(NUM_SRC-1){1'b0}}, 1'b1} << idx;
    return v;
  endfunction

endpackage

// File: rtl/controlador_interrupciones_codificador.sv
// Combinational priority encoder: lowest set bit wins (bit 0 = highest priority).
module codificador_prioridad
  import controlador_interrupciones_pkg::*;
(
  input  logic [NUM_SRC-1:0] i_req,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_found
);

  // Lowest-index request selection
  always_comb begin
    o_idx   = 3'd0;
    o_found = 1'b1;
    casez (i_req)
      8'b???????1: o_idx = 3'd0;
      8'b??????10: o_idx = 3'd1;
      8'b?????100: o_idx = 3'd2;
      8'b????1000: o_idx = 3'd3;
      8'b???10000: o_idx = 3'd4;
      8'b??100000: o_idx = 3'd5;
      8'b?1000000: o_idx = 3'd6;
      8'b10000000: o_idx = 3'd7;
      default: begin
        o_idx   = 3'd0;
        o_found = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/controlador_interrupciones.sv
// Eight-source interrupt controller: edge/level capture into a pending
// register, mask-gated priority selection and a REQ/SERVICE handshake FSM.
module controlador_interrupciones
  import controlador_interrupciones_pkg::*;
#(
  parameter bit               EDGE_MODE  = 1'b1,
  parameter logic [NUM_SRC-1:0] MASK_RESET = 8'h00
)(
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NUM_SRC-1:0] i_irq_src,
  input  logic               i_mask_we,
  input  logic [NUM_SRC-1:0] i_mask_d,
  input  logic               i_irq_ack,
  input  logic               i_irq_fin,
  output logic               o_irq_valid,
  output logic [IDX_W-1:0]   o_irq_num,
  output logic [NUM_SRC-1:0] o_pending,
  output logic [NUM_SRC-1:0] o_mask,
  output logic               o_busy
);

  logic [NUM_SRC-1:0] r_src_prev;
  logic [NUM_SRC-1:0] r_pending;
  logic [NUM_SRC-1:0] r_mask;
  estado_t            r_state;
  estado_t            w_state_next;
  logic [IDX_W-1:0]   r_irq_num;
  logic               r_irq_valid;
  logic               r_busy;
  logic [NUM_SRC-1:0] w_set;
  logic [NUM_SRC-1:0] w_clr;
  logic [NUM_SRC-1:0] w_sel;
  logic [IDX_W-1:0]   w_idx;
  logic               w_found;

  assign w_set = EDGE_MODE ? (i_irq_src & ~r_src_prev) : i_irq_src;
  assign w_sel = r_pending & r_mask;

  codificador_prioridad u_codificador (
    .i_req   (w_sel),
    .o_idx   (w_idx),
    .o_found (w_found)
  );

  // Next-state logic and ack-driven pending clear
  always_comb begin
    w_state_next = r_state;
    w_clr        = 8'h00;
    case (r_state)
      ST_IDLE: begin
        if (w_found) w_state_next = ST_REQ;
        else         w_state_next = ST_IDLE;
      end
      ST_REQ: begin
        if (i_irq_ack) begin
          w_state_next = ST_SERVICE;
          w_clr        = decodifica(r_irq_num);
        end else begin
          w_state_next = ST_REQ;
        end
      end
      ST_SERVICE: begin
        if (i_irq_fin) w_state_next = ST_IDLE;
        else           w_state_next = ST_SERVICE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  // Previous-cycle sample; reset also loads it so already-high sources stay quiet
  always_ff @(posedge i_clk) begin
    r_src_prev <= i_irq_src;
  end

  // Pending register: a new set wins over a same-cycle ack clear
  always_ff @(posedge i_clk) begin
    if (i_reset) r_pending <= 8'h00;
    else         r_pending <= (r_pending & ~w_clr) | w_set;
  end

  // Mask register; selection this cycle still sees the old value
  always_ff @(posedge i_clk) begin
    if (i_reset)        r_mask <= MASK_RESET;
    else if (i_mask_we) r_mask <= i_mask_d;
    else                r_mask <= r_mask;
  end

  // Registered handshake outputs and presented source number
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_irq_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_irq_num   <= 3'd0;
    end else begin
      r_irq_valid <= (w_state_next == ST_REQ);
      r_busy      <= (w_state_next == ST_SERVICE);
      if (r_state == ST_IDLE && w_found) r_irq_num <= w_idx;
      else if (w_state_next == ST_IDLE)  r_irq_num <= 3'd0;
      else                               r_irq_num <= r_irq_num;
    end
  end

  assign o_irq_valid = r_irq_valid;
  assign o_irq_num   = r_irq_num;
  assign o_pending   = r_pending;
  assign o_mask      = r_mask;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_controlador_interrupciones.sv
// Directed self-checking bench: edge-mode instance for most scenarios,
// level-mode instance for the set/clear collision.
module tb_controlador_interrupciones;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] src, mask_d, l_src, l_mask_d;
  logic       mask_we, ack, fin, l_mask_we, l_ack, l_fin;
  logic       valid, busy, l_valid, l_busy;
  logic [2:0] num, l_num;
  logic [7:0] pend, mask, l_pend, l_mask;
  logic [20:0] exp_s;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  controlador_interrupciones #(.EDGE_MODE(1'b1), .MASK_RESET(8'h00)) dut (
    .i_clk(clk), .i_reset(reset), .i_irq_src(src), .i_mask_we(mask_we),
    .i_mask_d(mask_d), .i_irq_ack(ack), .i_irq_fin(fin), .o_irq_valid(valid),
    .o_irq_num(num), .o_pending(pend), .o_mask(mask), .o_busy(busy));

  controlador_interrupciones #(.EDGE_MODE(1'b0), .MASK_RESET(8'h00)) dut_lvl (
    .i_clk(clk), .i_reset(reset), .i_irq_src(l_src), .i_mask_we(l_mask_we),
    .i_mask_d(l_mask_d), .i_irq_ack(l_ack), .i_irq_fin(l_fin), .o_irq_valid(l_valid),
    .o_irq_num(l_num), .o_pending(l_pend), .o_mask(l_mask), .o_busy(l_busy));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; src = 8'h00; mask_we = 1'b0; mask_d = 8'h00; ack = 1'b0; fin = 1'b0;
    l_src = 8'h00; l_mask_we = 1'b0; l_mask_d = 8'h00; l_ack = 1'b0; l_fin = 1'b0;
    tick(); tick();
    reset = 1'b0;
    exp_s = {1'b0, 1'b0, 3'd0, 8'h00, 8'h00};
    checks++;
    if ({valid, busy, num, pend, mask} !== exp_s) begin
      failures++; $display("FAIL reset_state got=%h exp=%h", {valid, busy, num, pend, mask}, exp_s);
    end
  endtask

  task automatic test_single();
    mask_we = 1'b1; mask_d = 8'hFF; tick(); mask_we = 1'b0;
    src = 8'h08; tick();
    checks++;
    if ({valid, busy, num, pend, mask} !== {1'b0, 1'b0, 3'd0, 8'h08, 8'hFF}) begin
      failures++; $display("FAIL single_pending got=%h exp=%h", {valid, busy, num, pend, mask}, {1'b0, 1'b0, 3'd0, 8'h08, 8'hFF});
    end
    tick();
    checks++;
    if ({valid, busy, num, pend} !== {1'b1, 1'b0, 3'd3, 8'h08}) begin
      failures++; $display("FAIL single_valid got=%h exp=%h", {valid, busy, num, pend}, {1'b1, 1'b0, 3'd3, 8'h08});
    end
    ack = 1'b1; tick(); ack = 1'b0;
    checks++;
    if ({valid, busy, num, pend} !== {1'b0, 1'b1, 3'd3, 8'h00}) begin
      failures++; $display("FAIL single_ack got=%h exp=%h", {valid, busy, num, pend}, {1'b0, 1'b1, 3'd3, 8'h00});
    end
    fin = 1'b1; tick(); fin = 1'b0;
    checks++;
    if ({valid, busy, num, pend} !== {1'b0, 1'b0, 3'd0, 8'h00}) begin
      failures++; $display("FAIL single_fin got=%h exp=%h", {valid, busy, num, pend}, {1'b0, 1'b0, 3'd0, 8'h00});
    end
    src = 8'h00; tick();
  endtask

  task automatic test_priority();
    src = 8'h24; tick(); tick();
    checks++;
    if ({valid, busy, num, pend} !== {1'b1, 1'b0, 3'd2, 8'h24}) begin
      failures++; $display("FAIL prio_first got=%h exp=%h", {valid, busy, num, pend}, {1'b1, 1'b0, 3'd2, 8'h24});
    end
    ack = 1'b1; tick(); ack = 1'b0;
    checks++;
    if ({valid, busy, num, pend} !== {1'b0, 1'b1, 3'd2, 8'h20}) begin
      failures++; $display("FAIL prio_ack got=%h exp=%h", {valid, busy, num, pend}, {1'b0, 1'b1, 3'd2, 8'h20});
    end
    fin = 1'b1; tick(); fin = 1'b0;
    checks++;
    if ({valid, busy, num} !== {1'b0, 1'b0, 3'd0}) begin
      failures++; $display("FAIL prio_gap got=%h exp=%h", {valid, busy, num}, {1'b0, 1'b0, 3'd0});
    end
    tick();
    checks++;
    if ({valid, busy, num, pend} !== {1'b1, 1'b0, 3'd5, 8'h20}) begin
      failures++; $display("FAIL prio_second got=%h exp=%h", {valid, busy, num, pend}, {1'b1, 1'b0, 3'd5, 8'h20});
    end
    ack = 1'b1; tick(); ack = 1'b0;
    fin = 1'b1; tick(); fin = 1'b0;
    src = 8'h00; tick();
  endtask

  task automatic test_masking();
    mask_we = 1'b1; mask_d = 8'hFB; tick(); mask_we = 1'b0;
    src = 8'h04; tick(); tick(); tick();
    checks++;
    if ({valid, busy, num, pend, mask} !== {1'b0, 1'b0, 3'd0, 8'h04, 8'hFB}) begin
      failures++; $display("FAIL mask_blocked got=%h exp=%h", {valid, busy, num, pend, mask}, {1'b0, 1'b0, 3'd0, 8'h04, 8'hFB});
    end
    mask_we = 1'b1; mask_d = 8'hFF; tick(); mask_we = 1'b0;
    checks++;
    if ({valid, mask} !== {1'b0, 8'hFF}) begin
      failures++; $display("FAIL mask_old_used got=%h exp=%h", {valid, mask}, {1'b0, 8'hFF});
    end
    tick();
    checks++;
    if ({valid, busy, num, pend} !== {1'b1, 1'b0, 3'd2, 8'h04}) begin
      failures++; $display("FAIL mask_unblocked got=%h exp=%h", {valid, busy, num, pend}, {1'b1, 1'b0, 3'd2, 8'h04});
    end
    ack = 1'b1; tick(); ack = 1'b0;
    fin = 1'b1; tick(); fin = 1'b0;
    src = 8'h00; tick();
  endtask

  task automatic test_stray();
    mask_we = 1'b1; mask_d = 8'h00; tick(); mask_we = 1'b0;
    src = 8'h10; tick(); src = 8'h00;
    ack = 1'b1; fin = 1'b1; tick(); ack = 1'b0; fin = 1'b0;
    checks++;
    if ({valid, busy, num, pend, mask} !== {1'b0, 1'b0, 3'd0, 8'h10, 8'h00}) begin
      failures++; $display("FAIL stray_idle got=%h exp=%h", {valid, busy, num, pend, mask}, {1'b0, 1'b0, 3'd0, 8'h10, 8'h00});
    end
    mask_we = 1'b1; mask_d = 8'hFF; tick(); mask_we = 1'b0;
    tick();
    checks++;
    if ({valid, busy, num, pend} !== {1'b1, 1'b0, 3'd4, 8'h10}) begin
      failures++; $display("FAIL stray_later got=%h exp=%h", {valid, busy, num, pend}, {1'b1, 1'b0, 3'd4, 8'h10});
    end
    ack = 1'b1; tick(); ack = 1'b0;
    fin = 1'b1; tick(); fin = 1'b0;
  endtask

  task automatic test_reset_mid_service();
    src = 8'h01; tick(); tick();
    ack = 1'b1; tick(); ack = 1'b0;
    checks++;
    if ({valid, busy, num, pend} !== {1'b0, 1'b1, 3'd0, 8'h00}) begin
      failures++; $display("FAIL rst_pre_service got=%h exp=%h", {valid, busy, num, pend}, {1'b0, 1'b1, 3'd0, 8'h00});
    end
    reset = 1'b1; tick(); reset = 1'b0;
    checks++;
    if ({valid, busy, num, pend, mask} !== {1'b0, 1'b0, 3'd0, 8'h00, 8'h00}) begin
      failures++; $display("FAIL rst_mid_service got=%h exp=%h", {valid, busy, num, pend, mask}, {1'b0, 1'b0, 3'd0, 8'h00, 8'h00});
    end
    mask_we = 1'b1; mask_d = 8'hFF; tick(); mask_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({valid, busy, pend} !== {1'b0, 1'b0, 8'h00}) begin
        failures++; $display("FAIL rst_no_refire[%0d] got=%h exp=%h", i, {valid, busy, pend}, {1'b0, 1'b0, 8'h00});
      end
    end
    src = 8'h00; tick();
  endtask

  task automatic test_collision();
    l_mask_we = 1'b1; l_mask_d = 8'hFF; tick(); l_mask_we = 1'b0;
    l_src = 8'h02; tick(); tick();
    checks++;
    if ({l_valid, l_busy, l_num, l_pend} !== {1'b1, 1'b0, 3'd1, 8'h02}) begin
      failures++; $display("FAIL coll_first got=%h exp=%h", {l_valid, l_busy, l_num, l_pend}, {1'b1, 1'b0, 3'd1, 8'h02});
    end
    l_ack = 1'b1; tick(); l_ack = 1'b0;
    checks++;
    if ({l_valid, l_busy, l_num, l_pend} !== {1'b0, 1'b1, 3'd1, 8'h02}) begin
      failures++; $display("FAIL coll_set_wins got=%h exp=%h", {l_valid, l_busy, l_num, l_pend}, {1'b0, 1'b1, 3'd1, 8'h02});
    end
    l_fin = 1'b1; tick(); l_fin = 1'b0;
    tick();
    checks++;
    if ({l_valid, l_busy, l_num, l_pend} !== {1'b1, 1'b0, 3'd1, 8'h02}) begin
      failures++; $display("FAIL coll_again got=%h exp=%h", {l_valid, l_busy, l_num, l_pend}, {1'b1, 1'b0, 3'd1, 8'h02});
    end
    l_src = 8'h00; l_ack = 1'b1; tick(); l_ack = 1'b0;
    checks++;
    if ({l_valid, l_busy, l_num, l_pend} !== {1'b0, 1'b1, 3'd1, 8'h00}) begin
      failures++; $display("FAIL coll_cleared got=%h exp=%h", {l_valid, l_busy, l_num, l_pend}, {1'b0, 1'b1, 3'd1, 8'h00});
    end
    l_fin = 1'b1; tick(); l_fin = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_masking();
    test_stray();
    test_reset_mid_service();
    test_collision();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/controlador_interrupciones.md
CONTROLADOR_INTERRUPCIONES -- requirements
Module: controlador_interrupciones

Interface
REQ-001 Parameter EDGE_MODE, default 1, 1 = rising-edge-triggered sources, 0 = level-triggered sources.
REQ-002 Parameter MASK_RESET, default 8'h00, mask register value after reset (all sources disabled).
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 irq_src  input  8  raw interrupt requests from devices; bit i = source i; bit 0 = highest priority.
REQ-006 mask_we  input  1  mask write strobe from the CPU.
REQ-007 mask_d  input  8  new mask value; 1 = source enabled.
REQ-008 irq_ack  input  1  CPU accepts the presented interrupt.
REQ-009 irq_fin  input  1  CPU finished the interrupt service routine.
REQ-010 irq_valid  output  1  an interrupt is being presented to the CPU.
REQ-011 irq_num  output  3  number of the presented source; drives the CPU interrupt input.
REQ-012 pending  output  8  pending register, for status reads.
REQ-013 mask  output  8  current mask register.
REQ-014 busy  output  1  an interrupt is in service.

Function
REQ-015 Edge mode: a source sets its pending bit when it is 1 in the current cycle and was 0 in the previous cycle; the previous-cycle sample is taken by a 1-cycle register.
REQ-016 Level mode: a source sets its pending bit in every cycle in which it is 1.
REQ-017 Pending bits are set regardless of mask; the mask only gates selection.
REQ-018 Selection: the lowest index i with pending[i] & mask[i] = 1.
REQ-019 FSM states:
- IDLE: the FSM moves to REQ on the clock edge after a selectable source exists, latching its index into irq_num.
- REQ: irq_valid = 1 and irq_num is held stable; on irq_ack the FSM clears pending[irq_num] and moves to SERVICE.
- SERVICE: busy = 1 and irq_valid = 0; on irq_fin the FSM moves to IDLE.
REQ-020 Latency: a source edge at cycle N gives pending set at N+1 and irq_valid at N+2.
REQ-021 The request is not withdrawn in REQ, even if its mask bit is cleared or a higher-priority source becomes pending; the next selection happens only in IDLE.
REQ-022 No nesting: new requests arriving during SERVICE only set pending bits.
REQ-023 If a pending set and an ack-clear hit the same bit in the same cycle, the set wins and the bit stays 1.
REQ-024 irq_ack outside REQ and irq_fin outside SERVICE are ignored.
REQ-025 When mask_we = 1, mask is loaded with mask_d on the next edge; a write in the same cycle as IDLE selection does not affect that selection (the old mask is used).
REQ-026 irq_num = 0 whenever irq_valid = 0 and busy = 0; in SERVICE, irq_num holds the serviced number.

Reset
REQ-027 On reset, all of the following take effect at the next clk edge, overriding all other inputs, including mid-REQ and mid-SERVICE:
- pending = 0 and mask = MASK_RESET;
- FSM = IDLE and irq_valid = 0, busy = 0, irq_num = 0;
- the edge-detect register is loaded with the current irq_src, so sources already high do not fire.

Structure
REQ-028 FSM state encodings (IDLE, REQ, SERVICE) and the source-count constant of 8 shall be placed in a shared package used by the CPU-side decode.
REQ-029 The priority encoder shall be a separate combinational sub-module, codificador_prioridad (8-bit in, 3-bit index plus found flag).
REQ-030 The design shall be a single clock domain with no latches, and irq_src is assumed already synchronous to clk.

Verification
REQ-031 The bench shall cover the following directed scenarios:
- Single request: mask = FF, irq_src[3] 0->1 at cycle 10 -> irq_valid = 1 and irq_num = 3 at cycle 12; ack -> pending[3] = 0 and busy = 1; fin -> IDLE.
- Priority: irq_src[5] and irq_src[2] rise together -> irq_num = 2 is served first; after fin, irq_num = 5 is presented 1 cycle later.
- Masking: mask = 8'hFB, irq_src[2] rises -> pending[2] = 1 and irq_valid stays 0; writing mask = FF -> irq_num = 2 is presented.
- Set/clear collision: with EDGE_MODE = 0, irq_src[1] is held high while ack for source 1 is given -> pending[1] stays 1 and is presented again after fin.
- Reset mid-SERVICE: reset = 1 for one cycle with irq_src[0] high -> all outputs are 0, mask = 00, and no request follows while irq_src[0] stays high.
- Stray handshakes: irq_ack and irq_fin pulsed in IDLE -> no state change and no pending bits cleared.
